// File: rtl/mem_stage_subword_pkg.sv
// Shared size codes, FSM encoding and alignment helper for the memory-stage
// sub-word front end.
package mem_stage_subword_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_MERGE = 1'b1;

  // The reserved size code 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/subword_lane.sv
// Combinational byte/halfword lane logic: extracts and extends a load value
// and builds the merged word for a sub-word store.
module subword_lane
  import mem_stage_subword_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [15:0] new_data_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = word_i[{addr_i[1], 4'b0000} +: 16];
    load_o   = word_i;
    merge_o  = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        merge_o[{addr_i, 3'b000} +: 8] = new_data_i[7:0];
      end
      SZ_HALF: begin
        load_o = {{16{signed_i & half_sel[15]}}, half_sel};
        merge_o[{addr_i[1], 4'b0000} +: 16] = new_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_subword.sv
// Memory-stage front end: word accesses pass straight through, sub-word
// stores become a two-cycle read-modify-write with a one-cycle stall.
module mem_stage_subword
  import mem_stage_subword_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [1:0]        MemSizeM,
  input  logic              LoadSignedM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [31:0]       WriteDataM,
  input  logic [31:0]       RAMReadData,
  output logic              RAMWrite,
  output logic [ADDR_W-1:0] RAMAddr,
  output logic [31:0]       RAMWD,
  output logic [31:0]       LoadDataM,
  output logic              StallM,
  output logic              AlignErrM,
  output logic [CNT_W-1:0]  RmwCount
);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [15:0]       data_q, data_d;
  logic [CNT_W-1:0]  rmw_count_q, rmw_count_d;

  logic        in_idle, misaligned, is_word;
  logic        word_store, sub_store, do_load;
  logic [1:0]  lane_addr, lane_size;
  logic [31:0] lane_load, lane_merge;

  always_comb begin
    in_idle    = (state_q == ST_IDLE);
    misaligned = is_misaligned(MemSizeM, ALUOutM[1:0]);
    is_word    = (MemSizeM != SZ_HALF) && (MemSizeM != SZ_BYTE);
    word_store = in_idle && MemWriteM && !misaligned && is_word;
    sub_store  = in_idle && MemWriteM && !misaligned && !is_word;
    // A simultaneous read+write is a store, so the load path stays quiet.
    do_load    = in_idle && MemReadM && !MemWriteM && !misaligned;
    lane_addr  = in_idle ? ALUOutM[1:0] : addr_q[1:0];
    lane_size  = in_idle ? MemSizeM : size_q;
  end

  // One lane unit serves both directions: live inputs in IDLE, latched in MERGE.
  subword_lane u_lane (
    .word_i     (RAMReadData),
    .addr_i     (lane_addr),
    .size_i     (lane_size),
    .signed_i   (LoadSignedM),
    .new_data_i (data_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  always_comb begin
    RAMWrite  = !RST && (word_store || (state_q == ST_MERGE));
    StallM    = !RST && sub_store;
    AlignErrM = in_idle && (MemReadM || MemWriteM) && misaligned;
    RAMAddr   = in_idle ? {ALUOutM[ADDR_W-1:2], 2'b00} : {addr_q[ADDR_W-1:2], 2'b00};
    RAMWD     = in_idle ? WriteDataM : lane_merge;
    LoadDataM = do_load ? lane_load : 32'h0;
    RmwCount  = rmw_count_q;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    data_d      = data_q;
    rmw_count_d = rmw_count_q;
    case (state_q)
      ST_IDLE: begin
        if (sub_store) begin
          state_d = ST_MERGE;
          addr_d  = ALUOutM;
          size_d  = MemSizeM;
          data_d  = WriteDataM[15:0];
        end
      end
      ST_MERGE: begin
        state_d     = ST_IDLE;
        rmw_count_d = rmw_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      data_q      <= '0;
      rmw_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      data_q      <= data_d;
      rmw_count_q <= rmw_count_d;
    end
  end

endmodule

// File: doc/mem_stage_subword.md
# mem_stage_subword

Memory-stage front end between the EX/MEM pipeline register and the word-only data RAM. It adds byte and halfword stores by sequencing a two-cycle read-modify-write, stalling the pipeline for one cycle while it does so. It also provides byte/halfword load extraction with sign or zero extension, and flags misaligned accesses. Word loads and word stores pass through in a single cycle.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of ALUOutM and RAMAddr.
- CNT_W, 16, width of the read-modify-write event counter.

Ports:
- CLK  in  1  pipeline clock. All state updates on posedge CLK.
- RST  in  1  asynchronous, active-high reset.
- MemWriteM  in  1  store in M stage.
- MemReadM  in  1  load in M stage.
- MemSizeM  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- LoadSignedM  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
- ALUOutM  in  ADDR_W  byte address.
- WriteDataM  in  32  store data; sub-word data is in the low bits.
- RAMReadData  in  32  word returned by the RAM (updated at negedge CLK).
- RAMWrite  out  1  write enable to RAM.
- RAMAddr  out  ADDR_W  byte address to RAM, word-aligned (bits [1:0] = 0).
- RAMWD  out  32  write data to RAM.
- LoadDataM  out  32  extracted and extended load result.
- StallM  out  1  holds IF/ID/EX/M pipeline registers.
- AlignErrM  out  1  misaligned access in M this cycle.
- RmwCount  out  CNT_W  number of completed read-modify-writes.

## Operation
- Byte lanes are little-endian: lane n = bits [8n+7:8n], selected by address bits [1:0]. Halfword lane h = bits [16h+15:16h], selected by address bit 1.
- Misaligned access:
  - Half with address bit 0 = 1, or word with address bits [1:0] ≠ 0.
  - Sets AlignErrM = 1 for any load or store.
  - No RAM write, no stall. LoadDataM = 0.
- FSM states IDLE and MERGE:
  - IDLE, aligned word store: RAMWrite = 1, RAMWD = WriteDataM. Stays in IDLE.
  - IDLE, aligned sub-word store: RAMWrite = 0, RAMAddr = word address, StallM = 1. Latch the address, size, and the low 16 bits of data into registers. Go to MERGE.
  - MERGE: RAMWD = RAMReadData with the selected lane(s) replaced from the latched data. RAMWrite = 1, RAMAddr = latched word address, StallM = 0. Next state is IDLE, and RmwCount increments.
  - MERGE uses only latched values, never live M-stage inputs.
- Loads (IDLE, MemReadM = 1, aligned):
  - LoadDataM = the selected lane, extended per LoadSignedM. Word loads pass through unchanged.
  - Loads never stall.
- MemReadM and MemWriteM both set: treated as a store. LoadDataM = 0.
- RmwCount wraps modulo 2^CNT_W.
- Outputs RAMWrite, StallM, and AlignErrM are combinational from the state and the inputs.

## Timing
- Reset values: state = IDLE, latched address/size/data = 0, RmwCount = 0. While RST = 1: RAMWrite = 0 and StallM = 0, with all other outputs combinational from inputs.
- Word store: written at the negedge of its M cycle (latency 1).
- Sub-word store:
  - Cycle 1 (IDLE): the RAM read happens at negedge.
  - Cycle 2 (MERGE): the merged write happens at negedge.
  - Total 2 cycles, with exactly one StallM cycle.
- Back-to-back sub-word stores: each takes 2 cycles (IDLE→MERGE→IDLE→MERGE).
- A load in the cycle after MERGE observes the merged word.
- RST asserted while in MERGE: go to IDLE immediately; the merge write is dropped (RAMWrite = 0).
- StallM is never high for 2 consecutive cycles.

## Structure
- A shared package holds:
  - size codes: SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10;
  - state encoding: ST_IDLE, ST_MERGE.
- One sub-module, subword_lane: combinational. Inputs: word, address[1:0], size, signed flag, new data. Outputs: the extracted and extended load value, and the merged store word. It is used for both directions.

## Test plan
- Word store 0xDEADBEEF to address 0x10, then a word load from 0x10. Expect LoadDataM = 0xDEADBEEF, no stall, RmwCount = 0.
- Word at 0x10 = 0xDEADBEEF; byte store 0x55 to 0x12. Expect StallM = 1 for one cycle, then RAM word = 0xDE55BEEF and RmwCount = 1.
- Halfword store 0x1234 to 0x12 on word 0xDE55BEEF gives 0x1234BEEF. A signed byte load from 0x11 then gives 0xFFFFFFBE; an unsigned load gives 0x000000BE.
- Halfword store to 0x13 and word load from 0x02: AlignErrM = 1, no RAM write, StallM = 0.
- Two consecutive byte stores (0xAA→0x20, 0xBB→0x21) on word 0 give 0x0000BBAA, with 2 stall cycles total and RmwCount += 2.
- RST pulsed during MERGE: RAM word is unchanged, state returns to IDLE, RmwCount = 0.
